// File: rtl/buf_grant_arbiter.sv
// rtl/buf_grant_arbiter.sv - round-robin req/rel grant arbiter for a shared single-port buffer
//
// Grants one requester at a time. Grants are registered and one-hot, and there is a
// dead cycle between owners. Optional hold timeout is enabled by BUF_ARB_TIMEOUT_EN.
//
// Ports:
//   clk           sole clock
//   rst           asynchronous active-high reset
//   enable        low forces all grants off; req is not arbitrated while low
//   req           level request per requester
//   rel           one-cycle release pulse per requester (only the owner's bit counts)
//   timeout_limit maximum hold cycles, 0 = unlimited (ignored without BUF_ARB_TIMEOUT_EN)
//   grant         one-hot registered grant (drives the memory mux select)
//   owner         binary index of the current/last owner, round-robin pointer
//   busy          OR of grant
//   timeout_evt   one-cycle pulse when a grant is revoked by timeout
module buf_grant_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   rel,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  output logic [NUM_REQ-1:0]   grant,
  output logic [2:0]           owner,
  output logic                 busy,
  output logic                 timeout_evt
);

  typedef enum logic [1:0] {IDLE, GRANT, RECOVER} state_t;

  state_t               state, state_d;
  logic [NUM_REQ-1:0]   grant_d;
  logic [2:0]           owner_d;
  logic                 evt_d;
  logic [2:0]           win;
  logic                 any_req;
  logic                 rel_own;
  logic                 to_hit;

  // Round-robin pick: scan owner+1, owner+2, ... modulo NUM_REQ. The outer loop runs
  // from the farthest offset down so that the nearest set request is the last write.
  always_comb begin
    win     = owner;
    any_req = |req;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (req[j] && (((int'(owner) + k) % NUM_REQ) == j)) begin
          win = 3'(j);
        end
      end
    end
  end

  // Release pulse of the current owner; all other rel bits are ignored.
  always_comb begin
    rel_own = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner == 3'(j)) begin
        rel_own = rel[j];
      end
    end
  end

`ifdef BUF_ARB_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] hold_cnt;

  // The counter reads 0 on the first grant cycle, so hitting limit-1 revokes after
  // exactly timeout_limit grant cycles.
  assign to_hit = (timeout_limit != '0) && (hold_cnt == (timeout_limit - CNT_ONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (enable && (state != GRANT) && any_req) begin
      hold_cnt <= '0;
    end else if (enable && (state == GRANT) && (hold_cnt != '1)) begin
      hold_cnt <= hold_cnt + CNT_ONE;
    end
  end
`else
  logic unused_timeout_limit;

  assign unused_timeout_limit = ^timeout_limit;
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d = state;
    grant_d = grant;
    owner_d = owner;
    evt_d   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      grant_d = '0;
    end else begin
      case (state)
        IDLE, RECOVER: begin
          if (any_req) begin
            state_d = GRANT;
            owner_d = win;
            for (int j = 0; j < NUM_REQ; j++) begin
              grant_d[j] = (win == 3'(j));
            end
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
        GRANT: begin
          // A release in the same cycle as a timeout wins and suppresses the event.
          if (rel_own) begin
            state_d = RECOVER;
            grant_d = '0;
          end else if (to_hit) begin
            state_d = RECOVER;
            grant_d = '0;
            evt_d   = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          grant_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      owner       <= 3'(NUM_REQ - 1);
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_d;
      grant       <= grant_d;
      owner       <= owner_d;
      timeout_evt <= evt_d;
    end
  end

  assign busy = |grant;

endmodule

// File: doc/buf_grant_arbiter.md
# buf_grant_arbiter

- Round-robin grant arbiter for a shared single-port resource: app_data registers, UDP RX/TX buffers, or payload memory.
- Serves up to NUM_REQ requesters, which may be HLS cores or the CPU.
- Requesters use the existing req/rel/grant protocol; grant is a registered one-hot vector, and a mandatory dead cycle separates owners.
- Sits between the ROS2 core, the CPU register interface and the shared memory mux; the one-hot grant drives that mux select directly.

## Interface
Parameters:
- NUM_REQ, default 3: number of requesters, 2..8.
- TIMEOUT_W, default 16: width of the hold-timeout counter and limit.

Ports:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  arbiter enable; low forces all grants off.
- req  in  NUM_REQ  level request per requester.
- rel  in  NUM_REQ  one-cycle release pulse per requester.
- timeout_limit  in  TIMEOUT_W  maximum hold cycles; 0 means no limit.
- grant  out  NUM_REQ  one-hot registered grant; at most one bit set.
- owner  out  3  binary index of the current/last owner.
- busy  out  1  high while any grant is set.
- timeout_evt  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
States: IDLE, GRANT, RECOVER.

Reset values:
- state=IDLE, grant=0, busy=0, timeout_evt=0.
- owner=NUM_REQ-1, so requester 0 wins first.
- hold counter=0.

IDLE:
- Any req bit set → arbitrate, go to GRANT.
- Arbitration is round-robin: search indices owner+1, owner+2, … modulo NUM_REQ; the first set req wins.
- The winner becomes owner; grant is set to the winner's one-hot bit; the hold counter is cleared.

GRANT:
- rel[owner] high → clear grant, go to RECOVER.
- rel on any non-owner bit is ignored.
- req[owner] dropping without rel does not release the grant.

RECOVER (exactly one cycle, grant=0):
- Arbitrates exactly as in IDLE using the current req.
- Any req set → GRANT; otherwise → IDLE.
- The releasing owner's own req is considered, but at lowest priority via the round-robin pointer.

Other rules:
- enable low in any state: next cycle grant=0, state=IDLE, timeout_evt=0.
  - owner and the round-robin pointer are retained.
  - req is not arbitrated while enable is low.
- rst mid-grant: grant clears immediately (asynchronously); no rel is required afterward.
- owner width is fixed at 3; upper bits are 0 when NUM_REQ<8.

## Timing
- Request latency: req rising at cycle t in IDLE → grant visible at t+1.
- Release: rel at t → grant low at t+1 (RECOVER); the next owner's grant is visible at t+2 at the earliest.
  - Minimum dead gap between owners: 1 cycle.
- Release and new request by a different requester in the same cycle t → that requester is granted at t+2.
- busy equals the OR of grant (same registered timing).

## Configuration
Macro: BUF_ARB_TIMEOUT_EN.

Defined:
- The hold counter increments each GRANT cycle, saturating at all-ones.
- When the counter equals timeout_limit-1 with timeout_limit≠0 and no rel present, the revoke behaves exactly like a release:
  - grant drops the next cycle;
  - timeout_evt pulses high in that same cycle;
  - state goes to RECOVER.
- rel and timeout in the same cycle: treated as a normal release, timeout_evt=0.
- timeout_limit is sampled continuously.

Undefined:
- No counter logic.
- timeout_limit is ignored; the port remains for interface stability.
- timeout_evt is tied 0.

## Test plan
- Reset with req=3'b111 → grant=001 one cycle after rst falls.
  - Then rel[0] → grant=000 for one cycle, then 010.
  - Then rel[1] → 100 (round-robin order 0,1,2).
- Single requester 2 holds req; rel[2] pulses every grant → grant toggles 100,000,100…; owner stays 2.
- Owner 0 granted, rel[1]/rel[2] pulsed, req[0] deasserted without rel → grant stays 001.
- enable dropped during grant=010 → grant=000 next cycle; req[1] is not regranted while enable=0.
  - Re-enable with req=3'b011 → grant=001 (pointer was 1).
- With BUF_ARB_TIMEOUT_EN and timeout_limit=5:
  - requester 0 granted and never releases → grant drops after exactly 5 grant cycles, timeout_evt=1 for one cycle, and requester 1 (holding req) is granted 1 cycle later.
  - With timeout_limit=0 the grant holds for 1000 cycles.
- rst asserted mid-grant=100 → grant=000 immediately (same cycle, asynchronous); after release owner=NUM_REQ-1, next grant to requester 0 if requested.
